// File: rtl/db15_serial_joy.sv
// Polls two DB15 pads through a 24-bit 74HC165 chain and publishes both button words once per frame.
// states: LOAD latch chain | SHIFT_LO sample bit | SHIFT_HI clock high | UPDATE publish (1 clk) | GAP idle
module db15_serial_joy #(
  parameter int CLK_DIV   = 20,
  parameter int GAP_TICKS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        present,
  output logic        frame_done
);

  localparam logic [2:0] ST_LOAD     = 3'd0;
  localparam logic [2:0] ST_SHIFT_LO = 3'd1;
  localparam logic [2:0] ST_SHIFT_HI = 3'd2;
  localparam logic [2:0] ST_UPDATE   = 3'd3;
  localparam logic [2:0] ST_GAP      = 3'd4;

  localparam logic [7:0] TC_LAST  = 8'(CLK_DIV - 1);
  localparam logic [9:0] GAP_LAST = 10'(GAP_TICKS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [9:0]  gap_q, gap_d;
  logic [23:0] shift_q, shift_d;
  logic [11:0] joy1_q, joy1_d, joy2_q, joy2_d;
  logic        present_q, present_d;
  logic        done_q, done_d;
  logic        load_q, load_d;
  logic        jclk_q, jclk_d;
  logic        sync1_q, sync2_q;
  logic        run_q;
  logic        tick;

  always_comb begin
    tick       = (tick_cnt_q == TC_LAST);
    state_d    = state_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    shift_d    = shift_q;
    joy1_d     = joy1_q;
    joy2_d     = joy2_q;
    present_d  = present_q;
    tick_cnt_d = tick ? 8'd0 : tick_cnt_q + 8'd1;
    // Hold the divider for the first clk out of reset so that LOAD spans a full CLK_DIV of low joy_load.
    if (!run_q) tick_cnt_d = 8'd0;

    case (state_q)
      ST_LOAD: if (tick) begin
        idx_d   = 5'd0;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: if (tick) begin
        shift_d[idx_q] = ~sync2_q;
        state_d        = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: if (tick) begin
        if (idx_q == 5'd23) begin
          state_d = ST_UPDATE;
        end else begin
          idx_d   = idx_q + 5'd1;
          state_d = ST_SHIFT_LO;
        end
      end
      ST_UPDATE: begin
        state_d    = ST_GAP;
        gap_d      = 10'd0;
        tick_cnt_d = 8'd0;
      end
      ST_GAP: if (tick) begin
        gap_d = gap_q + 10'd1;
        if (gap_q == GAP_LAST) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase

    // Outputs are registered from the next state so they are visible during UPDATE itself.
    done_d = (state_d == ST_UPDATE);
    if (done_d) begin
      if (&shift_q) begin
        joy1_d    = 12'd0;
        joy2_d    = 12'd0;
        present_d = 1'b0;
      end else begin
        joy1_d    = shift_q[11:0];
        joy2_d    = shift_q[23:12];
        present_d = 1'b1;
      end
    end
    load_d = (state_d != ST_LOAD);
    jclk_d = (state_d == ST_SHIFT_HI);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_LOAD;
      tick_cnt_q <= 8'd0;
      idx_q      <= 5'd0;
      gap_q      <= 10'd0;
      shift_q    <= 24'd0;
      joy1_q     <= 12'd0;
      joy2_q     <= 12'd0;
      present_q  <= 1'b0;
      done_q     <= 1'b0;
      load_q     <= 1'b1;
      jclk_q     <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      shift_q    <= shift_d;
      joy1_q     <= joy1_d;
      joy2_q     <= joy2_d;
      present_q  <= present_d;
      done_q     <= done_d;
      load_q     <= load_d;
      jclk_q     <= jclk_d;
      sync1_q    <= joy_data;
      sync2_q    <= sync1_q;
      run_q      <= 1'b1;
    end
  end

  assign joy_clk    = jclk_q;
  assign joy_load   = load_q;
  assign joystick1  = {4'd0, joy1_q};
  assign joystick2  = {4'd0, joy2_q};
  assign present    = present_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_db15_serial_joy.sv
// Bench for db15_serial_joy: live-button chain model, vector table, corner sequences and random frames.
module tb_db15_serial_joy;
  localparam int CLK_DIV   = 4;
  localparam int GAP_TICKS = 2;
  localparam int PERIOD    = (1 + 48 + GAP_TICKS) * CLK_DIV + 1;
  localparam int FIRST_LAT = 49 * CLK_DIV + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        joy_data;
  logic        joy_clk, joy_load, present, frame_done;
  logic [15:0] joystick1, joystick2;

  int n_tests = 0;
  int n_fail  = 0;

  db15_serial_joy #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk(clk), .reset(reset), .joy_data(joy_data), .joy_clk(joy_clk), .joy_load(joy_load),
    .joystick1(joystick1), .joystick2(joystick2), .present(present), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Chain model: pattern bit k (1 = pressed) is on the wire after k rising joy_clk edges since load.
  logic [23:0] pattern = 24'd0;
  int          mode = 0;          // 0 = chain, 1 = wire tied low, 2 = wire tied high
  logic [5:0]  bit_cnt = 6'd0;

  always @(posedge joy_clk or negedge joy_load)
    if (!joy_load) bit_cnt <= 6'd0;
    else if (bit_cnt < 6'd63) bit_cnt <= bit_cnt + 6'd1;

  always_comb begin
    joy_data = 1'b1;
    if (mode == 1) joy_data = 1'b0;
    else if (mode == 2) joy_data = 1'b1;
    else if (bit_cnt < 6'd24) joy_data = ~pattern[bit_cnt[4:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waveform and stability monitor
  int   cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  int   load_low, rises, high_run, bad_high, overlap, viol;
  int   prev_done = -1;
  logic clk_prev = 1'b0;
  logic [32:0] last_out = '0;

  initial begin
    load_low = 0; rises = 0; high_run = 0; bad_high = 0; overlap = 0; viol = 0;
  end

  always @(negedge clk) begin
    if (!rst_seen && !frame_done && {joystick1, joystick2, present} !== last_out) viol++;
    last_out = {joystick1, joystick2, present};
    if (rst_seen) begin
      load_low = 0; rises = 0; high_run = 0; bad_high = 0; overlap = 0;
      prev_done = -1;
    end else begin
      if (!joy_load) load_low++;
      if (!joy_load && joy_clk) overlap++;
      if (joy_clk) begin
        if (!clk_prev) rises++;
        high_run++;
      end else if (clk_prev) begin
        if (high_run != CLK_DIV) bad_high++;
        high_run = 0;
      end
      if (frame_done) begin
        check("load_low_clks", load_low, CLK_DIV);
        check("clk_rises", rises, 24);
        check("clk_high_len_bad", bad_high, 0);
        check("load_clk_overlap", overlap, 0);
        if (prev_done >= 0) check("frame_period", cyc - prev_done, PERIOD);
        prev_done = cyc;
        load_low = 0; rises = 0; bad_high = 0; overlap = 0;
      end
    end
    clk_prev = joy_clk;
  end

  task automatic wait_done(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_done && c < 400);
    if (!frame_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: no frame_done within %0d clks", name, c);
    end
  endtask

  task automatic wait_bit(input logic [5:0] b, input string name);
    int c;
    c = 0;
    while (bit_cnt != b && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (bit_cnt != b) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: bit %0d not reached, at %0d", name, b, bit_cnt);
    end
  endtask

  task automatic check_out(input string name, input logic [15:0] j1, input logic [15:0] j2, input logic p);
    check({name, "_j1"}, 32'(joystick1), 32'(j1));
    check({name, "_j2"}, 32'(joystick2), 32'(j2));
    check({name, "_present"}, 32'(present), 32'(p));
  endtask

  typedef struct {
    string       name;
    int          mode;
    logic [23:0] pat;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        pres;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [23:0] rp;
    logic [15:0] e1, e2;
    logic        ep;
    int          c;

    vecs[0] = '{"r_start",     0, 24'h800001, 16'h0001, 16'h0800, 1'b1};
    vecs[1] = '{"none",        0, 24'h000000, 16'h0000, 16'h0000, 1'b1};
    vecs[2] = '{"all_pressed", 0, 24'hFFFFFF, 16'h0000, 16'h0000, 1'b0};
    vecs[3] = '{"all_but_r",   0, 24'hFFFFFE, 16'h0FFE, 16'h0FFF, 1'b1};
    vecs[4] = '{"checker",     0, 24'h5A5A5A, 16'h0A5A, 16'h05A5, 1'b1};
    vecs[5] = '{"tied_low",    1, 24'h000000, 16'h0000, 16'h0000, 1'b0};
    vecs[6] = '{"tied_high",   2, 24'h000000, 16'h0000, 16'h0000, 1'b1};
    vecs[7] = '{"p1_start",    0, 24'h000800, 16'h0800, 16'h0000, 1'b1};

    mode    = vecs[0].mode;
    pattern = vecs[0].pat;
    repeat (3) @(negedge clk);
    check("rst_joy_load", 32'(joy_load), 32'd1);
    check("rst_joy_clk", 32'(joy_clk), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check_out("rst", 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      mode    = vecs[i].mode;
      pattern = vecs[i].pat;
      wait_done(vecs[i].name);
      check_out(vecs[i].name, vecs[i].j1, vecs[i].j2, vecs[i].pres);
    end

    // Pattern flips from all-P1-pressed to released while bit 10 is on the wire.
    pattern = {12'h000, 12'hFFF};
    wait_bit(6'd10, "midframe");
    pattern = 24'h000000;
    check_out("midframe_hold", 16'h0800, 16'h0000, 1'b1);
    wait_done("midframe");
    check_out("midframe", 16'h03FF, 16'h0000, 1'b1);

    // One-clk reset at bit 15 aborts the frame; next full frame must report the held pattern.
    pattern = 24'h123456;
    wait_bit(6'd15, "abort");
    reset = 1'b1;
    @(negedge clk);
    check("abort_rst_done", 32'(frame_done), 32'd0);
    check_out("abort_rst", 16'h0000, 16'h0000, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_load_low", 32'(joy_load), 32'd0);
    c = 1;
    while (!frame_done && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("abort_first_done_lat", c, FIRST_LAT);
    check_out("abort_next", 16'h0456, 16'h0123, 1'b1);

    // Random frames against the mapping rule
    for (int f = 0; f < 100; f++) begin
      if ($urandom_range(9) == 0) rp = 24'hFFFFFF;
      else rp = 24'($urandom);
      mode    = 0;
      pattern = rp;
      wait_done("rand");
      if (rp == 24'hFFFFFF) begin
        e1 = 16'h0; e2 = 16'h0; ep = 1'b0;
      end else begin
        e1 = 16'(rp % 4096);
        e2 = 16'(rp / 4096);
        ep = 1'b1;
      end
      check_out("rand", e1, e2, ep);
    end

    repeat (5) @(negedge clk);
    check("stable_between_frames", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
